// File: rtl/bpm_step_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bpm_step_gen_if : control and step/channel outputs of the tempo generator  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface bpm_step_gen_if #(
    parameter int BPM_W  = 8,
    parameter int NUM_CH = 4,
    parameter int STEP_W = 3
);
    logic                  go;
    logic [BPM_W-1:0]      bpm;
    logic [2*NUM_CH-1:0]   mode;
    logic                  running;
    logic                  tick;
    logic                  beat;
    logic                  bar;
    logic [STEP_W-1:0]     step;
    logic [NUM_CH-1:0]     ch_pulse;
    logic [NUM_CH-1:0]     ch_led;

    modport master (
        output go, bpm, mode,
        input  running, tick, beat, bar, step, ch_pulse, ch_led
    );

    modport slave (
        input  go, bpm, mode,
        output running, tick, beat, bar, step, ch_pulse, ch_led
    );
endinterface
`default_nettype wire

// File: rtl/bpm_step_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bpm_step_gen : phase-accumulator tempo/step generator with per-channel     |
// |                rhythm triggers and LED pulse stretchers                    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module bpm_step_gen #(
    parameter int CLK_HZ        = 50000000,
    parameter int BPM_W         = 8,
    parameter int SUBDIV        = 2,
    parameter int BEATS_PER_BAR = 4,
    parameter int NUM_CH        = 4,
    parameter int PULSE_CYC     = 5000000,
    parameter int ACC_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    bpm_step_gen_if.slave     bus
);

    localparam int                   STEPS    = SUBDIV * BEATS_PER_BAR;
    localparam int                   STEP_W   = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam longint unsigned      LIMIT_L  = 64'(CLK_HZ) * 64'd60;
    localparam logic [ACC_W-1:0]     LIMIT    = ACC_W'(LIMIT_L);
    localparam logic [STEP_W-1:0]    LAST     = STEP_W'(STEPS - 1);
    localparam logic [31:0]          SUB_U    = 32'(SUBDIV);
    localparam logic [31:0]          HALF_U   = 32'(SUBDIV / 2);
    localparam int                   CNT_W    = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
    localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(PULSE_CYC - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state, state_nx;
    logic [ACC_W-1:0]    acc, acc_nx, inc, sum;
    logic [BPM_W-1:0]    bpm_q, bpm_q_nx;
    logic [STEP_W-1:0]   step, step_nx;
    logic                running, running_nx;
    logic                tick, tick_nx;
    logic                beat, beat_nx;
    logic                bar, bar_nx;
    logic                fire;
    logic                clear;
    logic [31:0]         step_mod, step_mod_half;
    logic [NUM_CH-1:0]   ch_pulse, ch_led;

    always_comb begin
        state_nx      = state;
        acc_nx        = acc;
        bpm_q_nx      = bpm_q;
        step_nx       = step;
        running_nx    = running;
        tick_nx       = 1'b0;
        beat_nx       = 1'b0;
        bar_nx        = 1'b0;
        fire          = 1'b0;
        clear         = 1'b0;
        inc           = ACC_W'(bpm_q) * ACC_W'(SUBDIV);
        sum           = acc + inc;

        case (state)
            IDLE: begin
                bpm_q_nx = bus.bpm;
                acc_nx   = '0;
                if (bus.go && (bus.bpm != '0)) begin
                    state_nx   = RUN;
                    running_nx = 1'b1;
                    step_nx    = '0;
                    fire       = 1'b1;
                end
            end
            RUN: begin
                if (!bus.go) begin
                    state_nx   = IDLE;
                    running_nx = 1'b0;
                    acc_nx     = '0;
                    step_nx    = '0;
                    clear      = 1'b1;
                end else if (sum >= LIMIT) begin
                    acc_nx  = sum - LIMIT;
                    step_nx = (step == LAST) ? '0 : step + STEP_W'(1);
                    fire    = 1'b1;
                    // Tempo is only picked up on beat boundaries so a beat is never split
                    if ((32'(step_nx) % SUB_U) == 32'd0) begin
                        bpm_q_nx = bus.bpm;
                    end
                end else begin
                    acc_nx = sum;
                end
            end
            default: state_nx = IDLE;
        endcase

        step_mod      = 32'(step_nx) % SUB_U;
        step_mod_half = 32'(step_nx) % HALF_U;
        if (fire) begin
            tick_nx = 1'b1;
            beat_nx = (step_mod == 32'd0);
            bar_nx  = (step_nx == '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            acc     <= '0;
            bpm_q   <= '0;
            step    <= '0;
            running <= 1'b0;
            tick    <= 1'b0;
            beat    <= 1'b0;
            bar     <= 1'b0;
        end else begin
            state   <= state_nx;
            acc     <= acc_nx;
            bpm_q   <= bpm_q_nx;
            step    <= step_nx;
            running <= running_nx;
            tick    <= tick_nx;
            beat    <= beat_nx;
            bar     <= bar_nx;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic             hit;
        logic             trig;
        logic             pulse_r;
        logic             led_r;

        always_comb begin
            hit = 1'b0;
            case (bus.mode[2*i +: 2])
                2'b01:   hit = (step_mod == 32'd0);
                2'b10:   hit = (step_mod_half == 32'd0);
                2'b11:   hit = (step_mod == HALF_U);
                default: hit = 1'b0;
            endcase
            trig = fire & hit;
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt     <= '0;
                pulse_r <= 1'b0;
                led_r   <= 1'b0;
            end else if (clear) begin
                cnt     <= '0;
                pulse_r <= 1'b0;
                led_r   <= 1'b0;
            end else begin
                pulse_r <= trig;
                if (trig) begin
                    cnt   <= CNT_LOAD;
                    led_r <= 1'b1;
                end else if (cnt != '0) begin
                    cnt <= cnt - CNT_W'(1);
                end else begin
                    led_r <= 1'b0;
                end
            end
        end

        assign ch_pulse[i] = pulse_r;
        assign ch_led[i]   = led_r;
    end

    assign bus.running  = running;
    assign bus.tick     = tick;
    assign bus.beat     = beat;
    assign bus.bar      = bar;
    assign bus.step     = step;
    assign bus.ch_pulse = ch_pulse;
    assign bus.ch_led   = ch_led;

endmodule
`default_nettype wire
